// File: rtl/soc_system_pll_seq_pkg.sv
// Shared types and elaboration helpers for the system PLL reset/lock sequencer.
package soc_system_pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } seq_state_e;

  // Ceiling log2, floored at 1 so that it always yields a usable vector width.
  function automatic int clog2(input int value);
    int r;
    int x;
    r = 0;
    x = (value > 0) ? value - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/soc_system_sync2.sv
// Two-flop bit synchronizer, asynchronous active-high reset to 0.
module soc_system_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/soc_system_pll_seq.sv
// Reset and lock sequencer for the six-output system PLL, clocked by the PLL reference clock.
//   state     | meaning
//   PLL_RESET | pll_rst held high for PLL_RST_CYCLES
//   WAIT_LOCK | waiting for lock, timeout triggers a retry or FAULT
//   STABLE    | lock must stay high for LOCK_STABLE_CYCLES
//   RELEASE   | domain resets drop one by one, STAGGER_CYCLES apart
//   RUN       | all domains out of reset
//   FAULT     | retries exhausted, waits for soft_reset_req or rst
module soc_system_pll_seq
  import soc_system_pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int NUM_DOMAINS         = 6,
  parameter int STAGGER_CYCLES      = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                                refclk,
  input  logic                                rst,
  input  logic                                soft_reset_req,
  input  logic                                pll_locked,
  output logic                                pll_rst,
  output logic [NUM_DOMAINS-1:0]              domain_rst,
  output logic                                all_ready,
  output logic                                fault,
  output logic [clog2(MAX_RETRIES+1)-1:0]     retry_count,
  output logic                                lock_lost
);

  localparam int RC_W  = clog2(MAX_RETRIES + 1);
  localparam int CNT_W = clog2(max3(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES,
                                    NUM_DOMAINS * STAGGER_CYCLES) + 1);

  // Terminal counts: the counter reads 0 on the first cycle of a state.
  localparam logic [CNT_W-1:0] CNT_SAT      = '1;
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(NUM_DOMAINS * STAGGER_CYCLES - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX    = RC_W'(MAX_RETRIES);

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RC_W-1:0]        retry_q, retry_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   all_ready_q, all_ready_d;
  logic                   fault_q, fault_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   lock_s;
  logic                   cnt_clear;

  soc_system_sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    cnt_clear   = 1'b0;

    if (soft_reset_req) begin
      state_d   = PLL_RESET;
      retry_d   = '0;
      cnt_clear = 1'b1;
    end else if ((state_q == RELEASE || state_q == RUN) && !lock_s) begin
      // Reaching RELEASE requires lock_s high, so a low here is always a 1->0 drop.
      state_d     = PLL_RESET;
      retry_d     = '0;
      lock_lost_d = 1'b1;
    end else begin
      case (state_q)
        PLL_RESET: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RC_W'(1);
              state_d = PLL_RESET;
            end else begin
              state_d = FAULT;
            end
          end
        end
        STABLE: begin
          if (!lock_s)                  state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = RELEASE;
        end
        RELEASE:   if (cnt_q == RELEASE_LAST) state_d = RUN;
        RUN:       state_d = RUN;
        FAULT:     state_d = FAULT;
        default:   state_d = PLL_RESET;
      endcase
    end

    if (cnt_clear || state_d != state_q) cnt_d = '0;
    else if (cnt_q != CNT_SAT)           cnt_d = cnt_q + CNT_W'(1);
    else                                 cnt_d = cnt_q;

    // Outputs are derived from the next state so they change on the same edge as the state.
    pll_rst_d   = (state_d == PLL_RESET) || (state_d == FAULT);
    all_ready_d = (state_d == RUN);
    fault_d     = (state_d == FAULT);

    domain_rst_d = '1;
    if (state_d == RUN) begin
      domain_rst_d = '0;
    end else if (state_d == RELEASE && state_q == RELEASE) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        domain_rst_d[i] = (cnt_q < CNT_W'((i + 1) * STAGGER_CYCLES - 1));
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= PLL_RESET;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= '1;
      all_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      all_ready_q  <= all_ready_d;
      fault_q      <= fault_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign domain_rst  = domain_rst_q;
  assign all_ready   = all_ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_soc_system_pll_seq.sv
// Directed bench: per-cycle expected output snapshots are queued, then drained and compared.
module tb_soc_system_pll_seq;

  localparam int STG = 2;

  logic       refclk;
  logic       rst;
  logic       soft_reset_req;
  logic       pll_locked;
  logic       pll_rst;
  logic [5:0] domain_rst;
  logic       all_ready;
  logic       fault;
  logic [1:0] retry_count;
  logic       lock_lost;

  int checks = 0;
  int errors = 0;

  string      tag_q[$];
  logic [11:0] exp_q[$];

  soc_system_pll_seq #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .NUM_DOMAINS         (6),
    .STAGGER_CYCLES      (STG),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .soft_reset_req (soft_reset_req),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .domain_rst     (domain_rst),
    .all_ready      (all_ready),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_lost      (lock_lost)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Snapshot layout: {pll_rst, domain_rst[5:0], all_ready, fault, retry_count[1:0], lock_lost}
  function automatic logic [11:0] mk(logic p, logic [5:0] d, logic a, logic f,
                                     logic [1:0] r, logic l);
    return {p, d, a, f, r, l};
  endfunction

  // Domain i deasserts (i+1)*STG cycles after RELEASE entry at cycle e.
  function automatic logic [5:0] dom_mask(int k, int e);
    logic [5:0] m;
    for (int i = 0; i < 6; i++) m[i] = (k < e + STG * (i + 1));
    return m;
  endfunction

  task automatic push(input string tag, input int k, input logic [11:0] e);
    tag_q.push_back($sformatf("%s@%0d", tag, k));
    exp_q.push_back(e);
  endtask

  task automatic check_snap(input string tag, input logic [11:0] e);
    logic [11:0] obs;
    obs = {pll_rst, domain_rst, all_ready, fault, retry_count, lock_lost};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, e);
    end
  endtask

  task automatic drain();
    string       t;
    logic [11:0] e;
    while (exp_q.size() > 0) begin
      @(negedge refclk);
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_snap(t, e);
    end
  endtask

  initial begin
    rst            = 1'b1;
    soft_reset_req = 1'b0;
    pll_locked     = 1'b0;
    repeat (3) @(negedge refclk);
    check_snap("reset", mk(1, 6'h3F, 0, 0, 2'd0, 0));
    rst = 1'b0;

    // Normal bring-up: lock raised 10 cycles after reset release, RELEASE entered at cycle 21.
    for (int k = 1; k <= 10; k++) push("bringup", k, mk(k < 4, 6'h3F, 0, 0, 2'd0, 0));
    drain();
    pll_locked = 1'b1;
    for (int k = 11; k <= 35; k++)
      push("bringup", k, mk(0, dom_mask(k, 21), k >= 33, 0, 2'd0, 0));
    drain();

    // Lock loss in RUN: pulse three edges after the drop, then the sequence repeats.
    pll_locked = 1'b0;
    for (int k = 1; k <= 2; k++) push("run_hold", k, mk(0, 6'h00, 1, 0, 2'd0, 0));
    push("lock_lost", 3, mk(1, 6'h3F, 0, 0, 2'd0, 1));
    for (int k = 4; k <= 7; k++) push("relock_rst", k, mk(k < 7, 6'h3F, 0, 0, 2'd0, 0));
    drain();
    pll_locked = 1'b1;
    for (int k = 8; k <= 31; k++)
      push("relock", k, mk(0, dom_mask(k, 18), k >= 30, 0, 2'd0, 0));
    drain();

    // Soft reset from RUN (no lock_lost despite the simultaneous drop), then a glitchy lock.
    soft_reset_req = 1'b1;
    pll_locked     = 1'b0;
    push("soft_run", 1, mk(1, 6'h3F, 0, 0, 2'd0, 0));
    drain();
    soft_reset_req = 1'b0;
    for (int k = 2; k <= 5; k++) push("glitch_rst", k, mk(k < 5, 6'h3F, 0, 0, 2'd0, 0));
    drain();
    pll_locked = 1'b1;
    for (int k = 6; k <= 10; k++) push("glitch_hi", k, mk(0, 6'h3F, 0, 0, 2'd0, 0));
    drain();
    pll_locked = 1'b0;
    push("glitch_lo", 11, mk(0, 6'h3F, 0, 0, 2'd0, 0));
    drain();
    pll_locked = 1'b1;
    for (int k = 12; k <= 35; k++)
      push("glitch", k, mk(0, dom_mask(k, 22), k >= 34, 0, 2'd0, 0));
    drain();

    // One timeout (retry 1), then lock; soft reset while domains 0-2 are released.
    soft_reset_req = 1'b1;
    pll_locked     = 1'b0;
    push("soft2", 1, mk(1, 6'h3F, 0, 0, 2'd0, 0));
    drain();
    soft_reset_req = 1'b0;
    for (int k = 2; k <= 36; k++) push("to1", k, mk(k < 5, 6'h3F, 0, 0, 2'd0, 0));
    for (int k = 37; k <= 41; k++) push("retry1", k, mk(k < 41, 6'h3F, 0, 0, 2'd1, 0));
    drain();
    pll_locked = 1'b1;
    for (int k = 42; k <= 59; k++)
      push("rel_r1", k, mk(0, dom_mask(k, 52), 0, 0, 2'd1, 0));
    drain();
    soft_reset_req = 1'b1;
    push("soft_mid", 60, mk(1, 6'h3F, 0, 0, 2'd0, 0));
    drain();
    soft_reset_req = 1'b0;

    // Restart with lock held; assert rst asynchronously while in RELEASE.
    for (int k = 61; k <= 76; k++)
      push("rel2", k, mk(k < 64, dom_mask(k, 73), 0, 0, 2'd0, 0));
    drain();
    #1;
    rst        = 1'b1;
    pll_locked = 1'b0;
    #1;
    check_snap("rst_async", mk(1, 6'h3F, 0, 0, 2'd0, 0));

    // Timeout path: three PLL reset pulses, retry 0->1->2, then FAULT.
    @(negedge refclk);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++)    push("to_a", k, mk(1, 6'h3F, 0, 0, 2'd0, 0));
    for (int k = 4; k <= 35; k++)   push("to_a", k, mk(0, 6'h3F, 0, 0, 2'd0, 0));
    for (int k = 36; k <= 39; k++)  push("to_b", k, mk(1, 6'h3F, 0, 0, 2'd1, 0));
    for (int k = 40; k <= 71; k++)  push("to_b", k, mk(0, 6'h3F, 0, 0, 2'd1, 0));
    for (int k = 72; k <= 75; k++)  push("to_c", k, mk(1, 6'h3F, 0, 0, 2'd2, 0));
    for (int k = 76; k <= 107; k++) push("to_c", k, mk(0, 6'h3F, 0, 0, 2'd2, 0));
    for (int k = 108; k <= 112; k++) push("fault", k, mk(1, 6'h3F, 0, 1, 2'd2, 0));
    drain();
    soft_reset_req = 1'b1;
    push("fault_clr", 1, mk(1, 6'h3F, 0, 0, 2'd0, 0));
    drain();
    soft_reset_req = 1'b0;
    for (int k = 2; k <= 6; k++) push("post_fault", k, mk(k < 5, 6'h3F, 0, 0, 2'd0, 0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
